multicycle_ctrl: RTL

- Control FSM that sequences the RV32I datapath over multiple cycles: FETCH, DECODE, EXEC, MEM, WB.
- Consumes the one-hot instruction-class flags from the opcode decoder, plus branch-compare and memory handshake inputs.
- Drives PC, IR, register-file, ALU-operand and memory-request enables.
- Sits between the instruction/data memory ports and the datapath; counts retired instructions.

---
 rtl/ctrl_pkg.sv | 56 +++++
 rtl/ctrl_outdec.sv | 140 ++++++++++++++
 rtl/multicycle_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
//
// Shared types and constants for the multicycle RV32I control FSM.
//   state_e   : FSM states. TRAP exists only when ILLEGAL_TRAP_EN is defined.
//   pc_sel_e  : next-PC source select driven with pc_en_o.
//   wb_sel_e  : register-file write-back source select.
//   CLS_*     : bit positions of the one-hot instruction-class vector.
//   class_legal() : true when exactly one class flag is set.
//
// Build option: ILLEGAL_TRAP_EN adds the TRAP state.
// ---------------------------------------------------------------------------
package ctrl_pkg;

  localparam int CLS_W      = 8;
  localparam int CLS_R_TYPE = 0;
  localparam int CLS_I_TYPE = 1;
  localparam int CLS_LOAD   = 2;
  localparam int CLS_STORE  = 3;
  localparam int CLS_BRANCH = 4;
  localparam int CLS_JALR   = 5;
  localparam int CLS_JAL    = 6;
  localparam int CLS_LUI    = 7;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
`ifdef ILLEGAL_TRAP_EN
    ,
    TRAP   = 3'd5
`endif
  } state_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,  // PC + 4
    PC_BRANCH = 2'd1,  // PC + imm (taken branch, jal)
    PC_JALR   = 2'd2,  // (rs1 + imm) & ~1
    PC_TRAP   = 2'd3   // trap vector
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_LINK = 2'd2,    // PC + 4 for jal/jalr
    WB_IMM  = 2'd3     // lui
  } wb_sel_e;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic class_legal(input logic [CLS_W-1:0] cls);
    return (cls != '0) && ((cls & (cls - 8'd1)) == '0);
  endfunction

endpackage

// File: rtl/ctrl_outdec.sv
// ---------------------------------------------------------------------------
// ctrl_outdec
//
// Combinational output map of the multicycle controller. Every control
// output is a function of the registered state and the latched class
// register. The only input-dependent terms are the handshake completions
// that end a wait state in the same cycle (ir_en on imem_valid, store
// retire on dmem_ack) and the branch PC select in EXEC.
//
// Handshake semantics: a request (imem_req / dmem_req) is held high every
// cycle the FSM waits in FETCH / MEM; the transfer completes in the cycle
// the matching valid/ack is high, and the request may drop without
// completion when rst is asserted.
//
// Ports:
//   rst            : synchronous reset; forces every output to 0
//   state          : current FSM state
//   cls            : latched one-hot instruction class
//   branch_taken   : branch comparator result (used in EXEC)
//   imem_valid     : fetch data valid
//   dmem_ack       : data access complete
//   imem_req .. trap : control outputs, see multicycle_ctrl
//
// Build option: ILLEGAL_TRAP_EN enables the TRAP state decode.
// ---------------------------------------------------------------------------
module ctrl_outdec
  import ctrl_pkg::*;
(
  input  logic             rst,
  input  state_e           state,
  input  logic [CLS_W-1:0] cls,
  input  logic             branch_taken,
  input  logic             imem_valid,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_en,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             alu_b_imm,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic             trap
);

  logic legal;
  logic is_jump;

  assign legal   = class_legal(cls);
  assign is_jump = cls[CLS_JAL] | cls[CLS_JALR];

  always_comb begin
    imem_req  = 1'b0;
    ir_en     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_en     = 1'b0;
    pc_sel    = PC_PLUS4;
    alu_b_imm = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    retire    = 1'b0;
    trap      = 1'b0;

    if (!rst) begin
      case (state)
        FETCH: begin
          imem_req = 1'b1;
          ir_en    = imem_valid;
        end

        DECODE: begin
          // Class flags are being latched; nothing is driven.
        end

        EXEC: begin
          if (!legal) begin
            // Illegal class without the trap build behaves as a NOP.
            pc_en  = 1'b1;
            pc_sel = PC_PLUS4;
            retire = 1'b1;
          end else begin
            alu_b_imm = cls[CLS_I_TYPE] | cls[CLS_LOAD] | cls[CLS_STORE];
            if (cls[CLS_BRANCH]) begin
              pc_en  = 1'b1;
              pc_sel = branch_taken ? PC_BRANCH : PC_PLUS4;
              retire = 1'b1;
            end else if (cls[CLS_JAL]) begin
              pc_en  = 1'b1;
              pc_sel = PC_BRANCH;
            end else if (cls[CLS_JALR]) begin
              pc_en  = 1'b1;
              pc_sel = PC_JALR;
            end
          end
        end

        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = cls[CLS_STORE];
          // A store finishes in the ack cycle; a load still needs WB.
          if (dmem_ack && cls[CLS_STORE]) begin
            pc_en  = 1'b1;
            pc_sel = PC_PLUS4;
            retire = 1'b1;
          end
        end

        WB: begin
          rf_we  = 1'b1;
          retire = 1'b1;
          if (is_jump) begin
            wb_sel = WB_LINK;
          end else begin
            // Jumps already moved the PC in EXEC.
            pc_en  = 1'b1;
            pc_sel = PC_PLUS4;
            if (cls[CLS_LOAD])     wb_sel = WB_LOAD;
            else if (cls[CLS_LUI]) wb_sel = WB_IMM;
            else                   wb_sel = WB_ALU;
          end
        end

`ifdef ILLEGAL_TRAP_EN
        TRAP: begin
          trap   = 1'b1;
          pc_en  = 1'b1;
          pc_sel = PC_TRAP;
        end
`endif

        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Multicycle control FSM for an RV32I datapath. Sequences each instruction
// through FETCH, DECODE, EXEC, MEM and WB, drives the datapath enables and
// counts retired instructions.
//
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   *_type_i .. lui_i  : one-hot class flags from the decoder (DECODE)
//   branch_taken_i     : branch comparator result (EXEC)
//   imem_valid_i       : fetch data valid
//   dmem_ack_i         : data access complete
//   imem_req_o, ir_en_o, dmem_req_o, dmem_we_o, pc_en_o, pc_sel_o,
//   alu_b_imm_o, rf_we_o, wb_sel_o : datapath control
//   retire_o           : pulse in the last cycle of each instruction
//   instret_o          : retired count, wraps modulo 2^INSTRET_W
//   trap_o             : illegal-instruction pulse (trap build only)
//
// Parameter INSTRET_W : retired-counter width.
// Build option: ILLEGAL_TRAP_EN routes illegal classes to a TRAP state;
// without it they retire as a NOP and trap_o stays 0.
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 r_type_i,
  input  logic                 i_type_i,
  input  logic                 load_i,
  input  logic                 store_i,
  input  logic                 branch_i,
  input  logic                 jalr_i,
  input  logic                 jal_i,
  input  logic                 lui_i,
  input  logic                 branch_taken_i,
  input  logic                 imem_valid_i,
  input  logic                 dmem_ack_i,
  output logic                 imem_req_o,
  output logic                 ir_en_o,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic                 pc_en_o,
  output logic [1:0]           pc_sel_o,
  output logic                 alu_b_imm_o,
  output logic                 rf_we_o,
  output logic [1:0]           wb_sel_o,
  output logic                 retire_o,
  output logic [INSTRET_W-1:0] instret_o,
  output logic                 trap_o
);

  state_e                state_q;
  logic [CLS_W-1:0]      cls_q;
  logic [CLS_W-1:0]      flags;
  logic [INSTRET_W-1:0]  instret_q;

  assign flags = {lui_i, jal_i, jalr_i, branch_i,
                  store_i, load_i, i_type_i, r_type_i};

  // Every output reads 0 during reset, including the counter.
  assign instret_o = rst_i ? '0 : instret_q;

  ctrl_outdec u_outdec (
    .rst          (rst_i),
    .state        (state_q),
    .cls          (cls_q),
    .branch_taken (branch_taken_i),
    .imem_valid   (imem_valid_i),
    .dmem_ack     (dmem_ack_i),
    .imem_req     (imem_req_o),
    .ir_en        (ir_en_o),
    .dmem_req     (dmem_req_o),
    .dmem_we      (dmem_we_o),
    .pc_en        (pc_en_o),
    .pc_sel       (pc_sel_o),
    .alu_b_imm    (alu_b_imm_o),
    .rf_we        (rf_we_o),
    .wb_sel       (wb_sel_o),
    .retire       (retire_o),
    .trap         (trap_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= FETCH;
      cls_q     <= '0;
      instret_q <= '0;
    end else begin
      if (retire_o) begin
        instret_q <= instret_q + INSTRET_W'(1);
      end

      case (state_q)
        FETCH: begin
          if (imem_valid_i) state_q <= DECODE;
        end

        DECODE: begin
          cls_q <= flags;
`ifdef ILLEGAL_TRAP_EN
          state_q <= class_legal(flags) ? EXEC : TRAP;
`else
          state_q <= EXEC;
`endif
        end

        EXEC: begin
          if (!class_legal(cls_q))                 state_q <= FETCH;
          else if (cls_q[CLS_LOAD] | cls_q[CLS_STORE]) state_q <= MEM;
          else if (cls_q[CLS_BRANCH])              state_q <= FETCH;
          else                                     state_q <= WB;
        end

        MEM: begin
          if (dmem_ack_i) begin
            state_q <= cls_q[CLS_LOAD] ? WB : FETCH;
          end
        end

        WB: begin
          state_q <= FETCH;
        end

`ifdef ILLEGAL_TRAP_EN
        TRAP: begin
          state_q <= FETCH;
        end
`endif

        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

endmodule
